// File: rtl/fetch_s12.sv
// -----------------------------------------------------------------------------
// fetch_s12 -- instruction fetch stage with a stage-1/2 pipeline register.
//
// Holds the fetch PC (driven straight onto imem_addr) and a stage-1/2 register
// that carries {pc_s2, pc_nxt_s2, instr_s2, valid_s2} into decode. A two-state
// controller (BOOT, RUN) inserts one bubble after reset. In RUN, each edge does
// exactly one of the following, in priority order:
//   - take a redirect from stage 3,
//   - hold on a stall,
//   - advance the PC by 4.
// A redirect costs exactly one bubble. The block also keeps a sticky
// misaligned-target flag and a saturating count of accepted redirects.
//
// Parameters
//   RESET_PC   fetch address loaded on reset
//   NOP_INSTR  bubble instruction placed on instr_s2
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   stall      hold PC and the stage-1/2 register
//   pc_sel     redirect request (taken branch/jump from stage 3)
//   br_target  redirect address, valid when pc_sel=1
//   imem_data  instruction read combinationally at imem_addr
//   imem_addr  current fetch PC
//   pc_s2      PC of the instruction held for stage 2
//   pc_nxt_s2  pc_s2 + 4
//   instr_s2   instruction held for stage 2
//   valid_s2   1 = real instruction, 0 = bubble
//   align_err  sticky: a redirect target with br_target[1:0] != 0 was taken
//   redir_cnt  saturating count of accepted redirects
// -----------------------------------------------------------------------------
module fetch_s12 #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_sel,
  input  logic [31:0] br_target,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_s2,
  output logic [31:0] pc_nxt_s2,
  output logic [31:0] instr_s2,
  output logic        valid_s2,
  output logic        align_err,
  output logic [15:0] redir_cnt
);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // NOTE: declaration initialisers give the same power-up values as reset,
  // so the outputs are defined before the first reset edge arrives.
  logic [0:0]  state_q     = ST_BOOT;
  logic [31:0] pc_q        = RESET_PC;
  logic [31:0] pc_s2_q     = 32'h0;
  logic [31:0] pc_nxt_s2_q = 32'h0;
  logic [31:0] instr_s2_q  = NOP_INSTR;
  logic        valid_s2_q  = 1'b0;
  logic        align_err_q = 1'b0;
  logic [15:0] redir_cnt_q = 16'h0;

  logic [31:0] pc_plus4;

  // 32-bit add wraps 32'hFFFF_FFFC to 0 naturally.
  assign pc_plus4 = pc_q + 32'd4;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others (pc_s2 gets the old PC, not PC+4).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      pc_s2_q     <= 32'h0;
      pc_nxt_s2_q <= 32'h0;
      instr_s2_q  <= NOP_INSTR;
      valid_s2_q  <= 1'b0;
      align_err_q <= 1'b0;
      redir_cnt_q <= 16'h0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          // Stall and redirect are ignored here; one bubble goes to stage 2.
          state_q     <= ST_RUN;
          pc_q        <= RESET_PC;
          pc_s2_q     <= 32'h0;
          pc_nxt_s2_q <= 32'h0;
          instr_s2_q  <= NOP_INSTR;
          valid_s2_q  <= 1'b0;
        end
        default: begin
          if (pc_sel) begin
            // A redirect beats a stall. The instruction at the old PC is
            // dropped and replaced by a bubble.
            pc_q        <= {br_target[31:2], 2'b00};
            pc_s2_q     <= 32'h0;
            pc_nxt_s2_q <= 32'h0;
            instr_s2_q  <= NOP_INSTR;
            valid_s2_q  <= 1'b0;
            if (br_target[1:0] != 2'b00) align_err_q <= 1'b1;
            if (redir_cnt_q != 16'hFFFF) redir_cnt_q <= redir_cnt_q + 16'd1;
          end else if (!stall) begin
            pc_q        <= pc_plus4;
            pc_s2_q     <= pc_q;
            pc_nxt_s2_q <= pc_plus4;
            instr_s2_q  <= imem_data;
            valid_s2_q  <= 1'b1;
          end
          // On a stall without a redirect, every register keeps its value.
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign pc_s2     = pc_s2_q;
  assign pc_nxt_s2 = pc_nxt_s2_q;
  assign instr_s2  = instr_s2_q;
  assign valid_s2  = valid_s2_q;
  assign align_err = align_err_q;
  assign redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_fetch_s12.sv
// -----------------------------------------------------------------------------
// tb_fetch_s12 -- self-checking bench for fetch_s12.
// Instruction memory returns addr | 0xA000_0000. A reference model, written
// as plain per-edge rules, predicts every output. The bench runs directed
// scenarios followed by randomised stall/redirect/reset traffic.
// -----------------------------------------------------------------------------
module tb_fetch_s12;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] IMEM_TAG  = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic [31:0] imem_data;
  logic [31:0] imem_addr, pc_s2, pc_nxt_s2, instr_s2;
  logic        valid_s2, align_err;
  logic [15:0] redir_cnt;

  fetch_s12 #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel),
    .br_target(br_target), .imem_data(imem_data),
    .imem_addr(imem_addr), .pc_s2(pc_s2), .pc_nxt_s2(pc_nxt_s2),
    .instr_s2(instr_s2), .valid_s2(valid_s2), .align_err(align_err),
    .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory stimulus: contents are a fixed function of address.
  assign imem_data = imem_addr | IMEM_TAG;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit          m_boot  = 1'b1;
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_pc_s2 = 32'h0;
  logic [31:0] m_nxt   = 32'h0;
  logic [31:0] m_instr = NOP_INSTR;
  bit          m_valid = 1'b0;
  bit          m_err   = 1'b0;
  int          m_cnt   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | IMEM_TAG;
  endfunction

  task automatic model_bubble();
    m_pc_s2 = 32'h0; m_nxt = 32'h0; m_instr = NOP_INSTR; m_valid = 1'b0;
  endtask

  task automatic model_edge(input bit r, input bit s, input bit p, input logic [31:0] bt);
    if (r) begin
      m_boot = 1'b1; m_pc = RESET_PC; model_bubble(); m_err = 1'b0; m_cnt = 0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_pc = RESET_PC; model_bubble();
    end else if (p) begin
      m_pc = (bt / 4) * 4;
      model_bubble();
      if (bt % 4 != 0) m_err = 1'b1;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else if (!s) begin
      m_pc_s2 = m_pc;
      m_nxt   = m_pc + 32'd4;
      m_instr = mem_word(m_pc);
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".imem_addr"}, imem_addr, m_pc);
    check({tag, ".pc_s2"},     pc_s2,     m_pc_s2);
    check({tag, ".pc_nxt_s2"}, pc_nxt_s2, m_nxt);
    check({tag, ".instr_s2"},  instr_s2,  m_instr);
    check({tag, ".valid_s2"},  {31'b0, valid_s2},  {31'b0, m_valid});
    check({tag, ".align_err"}, {31'b0, align_err}, {31'b0, m_err});
    check({tag, ".redir_cnt"}, {16'b0, redir_cnt}, m_cnt[31:0]);
  endtask

  // One clock: apply inputs, let the edge happen, update model, then compare
  // 1 ns after the edge.
  task automatic tick(input bit r, input bit s, input bit p, input logic [31:0] bt,
                      input string tag, input bit do_cmp);
    rst = r; stall = s; pc_sel = p; br_target = bt;
    @(posedge clk);
    model_edge(r, s, p, bt);
    #1;
    if (do_cmp) compare_all(tag);
  endtask

  task automatic run_to(input logic [31:0] target, input string tag);
    int budget = 1000;
    while (m_pc != target && budget > 0) begin
      tick(0, 0, 0, 0, tag, 1);
      budget--;
    end
    check({tag, ".reached"}, m_pc, target);
  endtask

  initial begin
    // Power-up state before any edge.
    #1;
    compare_all("power_up");

    // Reset for two cycles, then the BOOT bubble.
    tick(1, 0, 0, 0, "reset1", 1);
    tick(1, 0, 1, 32'h40, "reset2", 1);
    tick(0, 1, 1, 32'h80, "boot_bubble", 1);   // BOOT ignores stall/pc_sel
    check("boot.no_count", {16'b0, redir_cnt}, 32'h0);

    // Sequential fetch: instr_s2 = 0xA000_0000, 0xA000_0004, ...
    tick(0, 0, 0, 0, "seq0", 1);
    check("seq0.instr", instr_s2, 32'hA000_0000);
    tick(0, 0, 0, 0, "seq1", 1);
    check("seq1.pc_s2", pc_s2, 32'h4);

    // Stall for three cycles at PC 0x10.
    run_to(32'h10, "to_10");
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 0, 0, "stall", 1);
      check("stall.addr", imem_addr, 32'h10);
    end
    tick(0, 0, 0, 0, "stall_release", 1);
    check("resume.pc_s2", pc_s2, 32'h10);

    // Redirect to 0x100 from PC 0x20: one bubble, then target instruction.
    run_to(32'h20, "to_20");
    tick(0, 0, 1, 32'h100, "redir", 1);
    check("redir.addr",  imem_addr, 32'h100);
    check("redir.instr", instr_s2,  NOP_INSTR);
    tick(0, 0, 0, 0, "after_redir", 1);
    check("after_redir.instr", instr_s2, 32'hA000_0100);
    check("after_redir.cnt", {16'b0, redir_cnt}, 32'd1);

    // Redirect coincident with stall, misaligned target.
    tick(0, 1, 1, 32'h203, "redir_stall", 1);
    check("redir_stall.addr", imem_addr, 32'h200);
    check("redir_stall.err", {31'b0, align_err}, 32'd1);

    // Back-to-back redirects: last target wins, each counted.
    tick(0, 0, 1, 32'h300, "b2b0", 1);
    tick(0, 0, 1, 32'h400, "b2b1", 1);
    tick(0, 0, 0, 0, "b2b_after", 1);
    check("b2b.instr", instr_s2, 32'hA000_0400);

    // PC wrap-around.
    tick(0, 0, 1, 32'hFFFF_FFFC, "to_top", 1);
    tick(0, 0, 0, 0, "wrap", 1);
    check("wrap.addr", imem_addr, 32'h0);
    check("wrap.nxt",  pc_nxt_s2, 32'h0);

    // Drive the redirect counter to saturation, then one more redirect.
    while (m_cnt < 65535) tick(0, 0, 1, 32'h8, "sat_fill", 0);
    compare_all("sat_full");
    tick(0, 0, 1, 32'hC, "sat_extra", 1);
    check("sat.hold", {16'b0, redir_cnt}, 32'h0000_FFFF);

    // Reset coincident with redirect: redirect dropped, counters cleared.
    tick(1, 0, 1, 32'h40, "rst_redir", 1);
    check("rst_redir.cnt", {16'b0, redir_cnt}, 32'h0);
    tick(0, 0, 0, 0, "rst_boot", 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, s, p;
      logic [31:0] bt;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 30);
      p  = ($urandom_range(0, 99) < 15);
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      tick(r, s, p, bt, "rand", 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
